seg_mux_scheduler: RTL



---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg_mux_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: blank pattern, scan states and the
// active-low abcdefg hex decode table.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to active-low abcdefg segment decode.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = seg7_decode(hex);

endmodule

// File: rtl/seg_mux_scheduler.sv
// Multiplexed common-anode 7-segment scanner: blanking gap then a lit slot per digit.
// Optional leading-zero blanking is enabled by defining SEG_MUX_LZB_EN.
module seg_mux_scheduler
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            enable,
  input  logic                                            wr_en,
  input  logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] wr_addr,
  input  logic [3:0]                                      wr_data,
  output logic [6:0]                                      seg,
  output logic [NUM_DIGITS-1:0]                           an,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                            frame_done
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx_n;
  logic [6:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic            fd_n;

  logic [3:0]      digits [NUM_DIGITS];
  logic [6:0]      cur_seg;
  logic            blank_cur;

  seg7_hex_decode u_dec (
    .hex (digits[digit_idx]),
    .seg (cur_seg)
  );

`ifdef SEG_MUX_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lzero;
  logic                  run;

  always_comb begin
    run   = 1'b1;
    lzero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run      = run & (digits[i] == 4'd0);
      lzero[i] = run;
    end
  end

  assign blank_cur = (digit_idx != '0) && lzero[digit_idx];
`else
  assign blank_cur = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      digits[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= fd_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = digit_idx;
    seg_n   = seg;
    an_n    = an;
    fd_n    = 1'b0;

    case (state)
      IDLE: begin
        seg_n = SEG_OFF;
        an_n  = '1;
        idx_n = '0;
        cnt_n = '0;
        if (enable) state_n = BLANK;
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          if (blank_cur) begin
            seg_n = SEG_OFF;
            an_n  = '1;
          end else begin
            seg_n = cur_seg;
            an_n  = ~(NUM_DIGITS'(1) << digit_idx);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          seg_n   = SEG_OFF;
          an_n    = '1;
          if (digit_idx == LAST_IDX) begin
            idx_n = '0;
            fd_n  = 1'b1;
          end else begin
            idx_n = digit_idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Dropping enable abandons the current slot without a frame pulse.
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      seg_n   = SEG_OFF;
      an_n    = '1;
      fd_n    = 1'b0;
    end
  end

endmodule
